cdb_result_buffer: RTL

- Per-FU completion holding FIFO, directly upstream of the CDB arbiter, one instance per functional unit.
- Captures the FU's fu_complete_t results and presents the oldest as that FU's completion request.
- Pops the oldest entry when the arbiter grants that FU, so an FU can keep issuing while it loses CDB arbitration.
- Provides occupancy and almost-full backpressure so the FU or its issue logic can stall before overflow.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/cdb_result_buffer.sv | 102 ++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types used between functional units and the CDB.
package riscv_pkg;

  // One FU completion: ROB tag, result value and exception flag.
  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] value;
    logic        exc;
  } fu_complete_t;

endpackage

// File: rtl/cdb_result_buffer.sv
// Per-FU completion holding FIFO sitting in front of the CDB arbiter.
// Holds finished results while the FU loses arbitration, presents the
// oldest one as the FU's completion request and pops it on grant.
module cdb_result_buffer #(
  parameter int DEPTH           = 4,
  parameter int ALMOST_FULL_LVL = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  riscv_pkg::fu_complete_t    i_result,
  output riscv_pkg::fu_complete_t    o_fu_complete,
  input  logic                       i_grant,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_overflow,
  output logic                       o_spurious_grant
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF  = CW'(ALMOST_FULL_LVL);

  riscv_pkg::fu_complete_t r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_spurious;

  logic w_empty;
  logic w_is_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A pop frees the head slot in the same edge, so a full buffer can
  // still accept a push when it is also being granted.
  assign w_empty   = (r_count == '0);
  assign w_is_full = (r_count == CNT_MAX);
  assign w_pop     = i_grant && !w_empty && !i_flush;
  assign w_push    = i_result.valid && !i_flush && (!w_is_full || w_pop);
  assign w_drop    = i_result.valid && !i_flush && w_is_full && !w_pop;

  // Control state: pointers, occupancy counter and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      if (w_drop)
        r_overflow <= 1'b1;
      if (i_grant && w_empty)
        r_spurious <= 1'b1;
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage; data only, never reset.
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_result;
  end

  // Head presentation comes from storage only; zeros when empty so the
  // arbiter never sees X payload after reset.
  always_comb begin
    o_fu_complete = '0;
    if (!w_empty) begin
      o_fu_complete       = r_mem[r_rd_ptr];
      o_fu_complete.valid = 1'b1;
    end
  end

  assign o_count          = r_count;
  assign o_full           = w_is_full;
  assign o_almost_full    = (r_count >= CNT_AF);
  assign o_overflow       = r_overflow;
  assign o_spurious_grant = r_spurious;

endmodule
